// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel push-button front end.
// Each channel has a synchroniser, a counter-based debouncer, a clean level,
// one-cycle press/release pulses and an optional auto-repeat.
//
// Ports (top):
//   Clk        in   system clock, rising edge
//   Reset      in   synchronous active-high reset
//   Btn        in   [CHANNELS] raw asynchronous button pins
//   Repeat_En  in   [CHANNELS] per-channel auto-repeat enable
//   Level      out  [CHANNELS] debounced pressed state (1 = pressed)
//   Press      out  [CHANNELS] one-cycle pulse on accepted press or repeat
//   Release    out  [CHANNELS] one-cycle pulse on accepted release
//   Repeat     out  [CHANNELS] marks a Press pulse that is a repeat
//   Any_Press  out  OR of Press

// Per-channel conditioner.
//   i_clk, i_reset : clock / sync active-high reset
//   i_btn          : raw pin
//   i_rep_en       : auto-repeat enable
//   o_level, o_press, o_release, o_repeat : registered outputs
module button_conditioner_ch #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  input  logic i_rep_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);
  localparam int DCW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = $clog2(RMAX + 1);
  localparam logic [DCW-1:0] DC_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] RD_LAST = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RP_LAST = RCW'(REPEAT_PERIOD - 1);

  logic                   w_pressed;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic [DCW-1:0]         r_dcnt;
  logic                   r_level;
  logic [RCW-1:0]         r_rcnt;
  logic                   r_rep_phase;  // 0: waiting for first repeat, 1: periodic
  logic                   r_press, r_release, r_repeat;
  logic                   w_accept, w_acc_press, w_acc_rel;
  logic                   w_rep_active, w_rep_fire;

  // Normalise so that 1 always means pressed; reset loads the released value.
  assign w_pressed = (ACTIVE_LOW != 0) ? ~i_btn : i_btn;
  assign w_s       = r_sync[SYNC_STAGES-1];

  assign w_accept    = (w_s != r_level) && (r_dcnt == DC_LAST);
  assign w_acc_press = w_accept &  w_s;
  assign w_acc_rel   = w_accept & ~w_s;

  // Repeat timing runs only while held and enabled; a release accepted this
  // edge wins over a repeat that would otherwise fire in the same cycle.
  assign w_rep_active = r_level & i_rep_en;
  assign w_rep_fire   = w_rep_active & ~w_acc_rel &
                        (r_rep_phase ? (r_rcnt == RP_LAST) : (r_rcnt == RD_LAST));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync      <= '0;
      r_dcnt      <= '0;
      r_level     <= 1'b0;
      r_rcnt      <= '0;
      r_rep_phase <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_repeat    <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_pressed};

      if (w_s == r_level) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DC_LAST) begin
        r_level <= w_s;
        r_dcnt  <= '0;
      end else begin
        r_dcnt <= r_dcnt + DCW'(1);
      end

      r_press   <= w_acc_press | w_rep_fire;
      r_release <= w_acc_rel;
      r_repeat  <= w_rep_fire;

      if (!w_rep_active || w_acc_rel) begin
        r_rcnt      <= '0;
        r_rep_phase <= 1'b0;
      end else if (w_rep_fire) begin
        r_rcnt      <= '0;
        r_rep_phase <= 1'b1;
      end else begin
        r_rcnt <= r_rcnt + RCW'(1);
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;
endmodule

module button_conditioner #(
  parameter int CHANNELS        = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 3
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] Btn,
  input  logic [CHANNELS-1:0] Repeat_En,
  output logic [CHANNELS-1:0] Level,
  output logic [CHANNELS-1:0] Press,
  output logic [CHANNELS-1:0] Release,
  output logic [CHANNELS-1:0] Repeat,
  output logic                Any_Press
);
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    button_conditioner_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .i_clk    (Clk),
      .i_reset  (Reset),
      .i_btn    (Btn[g]),
      .i_rep_en (Repeat_En[g]),
      .o_level  (Level[g]),
      .o_press  (Press[g]),
      .o_release(Release[g]),
      .o_repeat (Repeat[g])
    );
  end

  assign Any_Press = |Press;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (defaults, CHANNELS=2, active-low pins).
// Expected pulse events are queued when stimulus is driven; a monitor pops and
// compares them on the cycle they are due and requires silence otherwise.
module tb_button_conditioner;
  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] Btn, Repeat_En;
  logic [1:0] Level, Press, Release, Repeat;
  logic       Any_Press;

  button_conditioner dut (
    .Clk(Clk), .Reset(Reset), .Btn(Btn), .Repeat_En(Repeat_En),
    .Level(Level), .Press(Press), .Release(Release), .Repeat(Repeat),
    .Any_Press(Any_Press)
  );

  always #5 Clk = ~Clk;

  int edge_n = 0;
  always @(posedge Clk) edge_n++;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] rep;
  } ev_t;
  ev_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s @edge %0d: observed %h expected %h", tag, edge_n, obs, exp);
    end
  endtask

  function automatic void push(input int c, input logic [1:0] p, input logic [1:0] r,
                               input logic [1:0] rp);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.rep = rp;
    sb.push_back(e);
  endfunction

  task automatic wait_to(input int c);
    while (edge_n < c) @(negedge Clk);
  endtask

  // Monitor: every cycle either a due event matches exactly, or nothing pulses.
  always @(negedge Clk) begin
    ev_t ev;
    if (sb.size() > 0 && sb[0].cyc == edge_n) begin
      ev = sb.pop_front();
      chk("press",   {6'b0, Press},     {6'b0, ev.press});
      chk("release", {6'b0, Release},   {6'b0, ev.rel});
      chk("repeat",  {6'b0, Repeat},    {6'b0, ev.rep});
      chk("any",     {7'b0, Any_Press}, {7'b0, |ev.press});
    end else begin
      chk("quiet", {1'b0, Press, Release, Repeat, Any_Press}, 8'h00);
    end
  end

  int e, L;

  initial begin
    Reset = 1'b1; Btn = 2'b11; Repeat_En = 2'b00;
    repeat (3) @(negedge Clk);
    chk("rst_level", {6'b0, Level}, 8'h00);
    Reset = 1'b0;
    repeat (20) @(negedge Clk);
    chk("idle_level", {6'b0, Level}, 8'h00);

    // Clean press on channel 0
    Btn[0] = 1'b0; e = edge_n + 6; push(e, 2'b01, 2'b00, 2'b00);
    wait_to(e - 1); chk("press0_early", {6'b0, Level}, 8'h00);
    wait_to(e);     chk("press0_level", {6'b0, Level}, 8'h01);
    wait_to(e + 40);

    // 3-cycle bounce on channel 1 is rejected
    Btn[1] = 1'b0; repeat (3) @(negedge Clk); Btn[1] = 1'b1;
    repeat (12) @(negedge Clk);
    chk("bounce_level", {6'b0, Level}, 8'h01);
    // Stable press on channel 1
    Btn[1] = 1'b0; e = edge_n + 6; push(e, 2'b10, 2'b00, 2'b00);
    wait_to(e); chk("press1_level", {6'b0, Level}, 8'h03);
    repeat (5) @(negedge Clk);

    // Release channel 0
    Btn[0] = 1'b1; e = edge_n + 6; push(e, 2'b00, 2'b01, 2'b00);
    wait_to(e - 1); chk("rel0_early", {6'b0, Level}, 8'h03);
    wait_to(e);     chk("rel0_level", {6'b0, Level}, 8'h02);
    repeat (5) @(negedge Clk);

    // Auto-repeat, released exactly on a would-be repeat cycle (L+23)
    Repeat_En[0] = 1'b1; repeat (3) @(negedge Clk);
    Btn[0] = 1'b0; L = edge_n + 6;
    push(L, 2'b01, 2'b00, 2'b00);
    for (int k = 8; k <= 20; k += 3) push(L + k, 2'b01, 2'b00, 2'b01);
    wait_to(L + 17);
    Btn[0] = 1'b1; push(L + 23, 2'b00, 2'b01, 2'b00);
    wait_to(L + 23); chk("rep_rel_level", {6'b0, Level}, 8'h02);
    repeat (5) @(negedge Clk);

    // Auto-repeat stopped by dropping Repeat_En at L+12
    Btn[0] = 1'b0; L = edge_n + 6;
    push(L, 2'b01, 2'b00, 2'b00);
    push(L + 8,  2'b01, 2'b00, 2'b01);
    push(L + 11, 2'b01, 2'b00, 2'b01);
    wait_to(L + 12); Repeat_En[0] = 1'b0;
    wait_to(L + 30); chk("rep_stop_level", {6'b0, Level}, 8'h03);
    Btn[0] = 1'b1; e = edge_n + 6; push(e, 2'b00, 2'b01, 2'b00);
    wait_to(e);
    Btn[1] = 1'b1; e = edge_n + 6; push(e, 2'b00, 2'b10, 2'b00);
    wait_to(e); chk("all_released", {6'b0, Level}, 8'h00);
    repeat (3) @(negedge Clk);

    // Simultaneous press, then reset mid-hold
    Btn = 2'b00; e = edge_n + 6; push(e, 2'b11, 2'b00, 2'b00);
    wait_to(e); chk("sim_level", {6'b0, Level}, 8'h03);
    repeat (4) @(negedge Clk);
    Reset = 1'b1; @(negedge Clk);
    chk("midrst_level", {6'b0, Level}, 8'h00);
    @(negedge Clk);
    Reset = 1'b0; e = edge_n + 6; push(e, 2'b11, 2'b00, 2'b00);
    wait_to(e - 1); chk("rerun_early", {6'b0, Level}, 8'h00);
    wait_to(e);     chk("rerun_level", {6'b0, Level}, 8'h03);
    repeat (5) @(negedge Clk);

    chk("sb_empty", 8'(sb.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
